// File: rtl/io_port_fifo_bank.sv
// Per-port inbound/outbound FIFO bank between the Datapath I/O ports and external streams.
// Optional occupancy outputs in_count/out_count are enabled by IO_PORT_FIFO_BANK_OCCUPANCY_EN.

// Purpose: single circular-buffer FIFO with first-word fall-through head, zero when empty.
// Latency: push visible on the head one cycle later; pop updates the head after the same edge.
// Backpressure: none internally; the caller qualifies push/pop against the registered count.
module io_port_fifo_bank_fifo #(
    parameter int WORD_WIDTH  = 36,
    parameter int DEPTH       = 4,
    parameter int DEPTH_WIDTH = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic [WORD_WIDTH-1:0]  i_push_dat,
    input  logic                   i_pop,
    output logic [WORD_WIDTH-1:0]  o_head_dat,
    output logic [DEPTH_WIDTH:0]   o_count
);
    logic [WORD_WIDTH-1:0]  r_mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] r_wptr;
    logic [DEPTH_WIDTH-1:0] r_rptr;
    logic [DEPTH_WIDTH:0]   r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset: an empty FIFO masks its head to zero instead.
    always_ff @(posedge clock) begin
        if (i_push) r_mem[r_wptr] <= i_push_dat;
    end

    assign o_head_dat = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign o_count    = r_count;
endmodule

// Purpose: PORT_COUNT independent channels, each with an inbound and outbound FIFO (IO_PORT_FIFO_BANK_OCCUPANCY_EN adds counts).
// Latency: 1 cycle push-to-visible, flags and heads driven only from registered state.
// Backpressure: ready/EF from registered count; illegal Datapath rden/wren are dropped and set sticky protocol_error.
module io_port_fifo_bank #(
    parameter int WORD_WIDTH  = 36,
    parameter int PORT_COUNT  = 3,
    parameter int DEPTH       = 4,
    parameter int DEPTH_WIDTH = 2
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [PORT_COUNT-1:0]            io_rden,
    output logic [PORT_COUNT*WORD_WIDTH-1:0] io_read_data,
    output logic [PORT_COUNT-1:0]            io_read_EF,
    input  logic [PORT_COUNT-1:0]            io_wren,
    input  logic [PORT_COUNT*WORD_WIDTH-1:0] io_write_data,
    output logic [PORT_COUNT-1:0]            io_write_EF,
    input  logic [PORT_COUNT-1:0]            ext_in_valid,
    output logic [PORT_COUNT-1:0]            ext_in_ready,
    input  logic [PORT_COUNT*WORD_WIDTH-1:0] ext_in_data,
    output logic [PORT_COUNT-1:0]            ext_out_valid,
    input  logic [PORT_COUNT-1:0]            ext_out_ready,
    output logic [PORT_COUNT*WORD_WIDTH-1:0] ext_out_data,
    output logic [PORT_COUNT-1:0]            protocol_error
`ifdef IO_PORT_FIFO_BANK_OCCUPANCY_EN
    ,
    output logic [PORT_COUNT*(DEPTH_WIDTH+1)-1:0] in_count,
    output logic [PORT_COUNT*(DEPTH_WIDTH+1)-1:0] out_count
`endif
);
    localparam logic [DEPTH_WIDTH:0] FULL_CNT = (DEPTH_WIDTH+1)'(DEPTH);

    for (genvar g = 0; g < PORT_COUNT; g++) begin : g_port
        logic [DEPTH_WIDTH:0] w_in_cnt;
        logic [DEPTH_WIDTH:0] w_out_cnt;
        logic                 w_in_full;
        logic                 w_in_empty;
        logic                 w_out_full;
        logic                 w_out_empty;
        logic                 w_in_push;
        logic                 w_in_pop;
        logic                 w_out_push;
        logic                 w_out_pop;
        logic                 r_perr;

        assign w_in_full   = (w_in_cnt == FULL_CNT);
        assign w_in_empty  = (w_in_cnt == '0);
        assign w_out_full  = (w_out_cnt == FULL_CNT);
        assign w_out_empty = (w_out_cnt == '0);

        assign w_in_push  = ext_in_valid[g] & ~w_in_full;
        assign w_in_pop   = io_rden[g] & ~w_in_empty;
        assign w_out_push = io_wren[g] & ~w_out_full;
        assign w_out_pop  = ext_out_ready[g] & ~w_out_empty;

        io_port_fifo_bank_fifo #(
            .WORD_WIDTH (WORD_WIDTH),
            .DEPTH      (DEPTH),
            .DEPTH_WIDTH(DEPTH_WIDTH)
        ) u_in_fifo (
            .clock     (clock),
            .reset_n   (reset_n),
            .i_push    (w_in_push),
            .i_push_dat(ext_in_data[g*WORD_WIDTH +: WORD_WIDTH]),
            .i_pop     (w_in_pop),
            .o_head_dat(io_read_data[g*WORD_WIDTH +: WORD_WIDTH]),
            .o_count   (w_in_cnt)
        );

        io_port_fifo_bank_fifo #(
            .WORD_WIDTH (WORD_WIDTH),
            .DEPTH      (DEPTH),
            .DEPTH_WIDTH(DEPTH_WIDTH)
        ) u_out_fifo (
            .clock     (clock),
            .reset_n   (reset_n),
            .i_push    (w_out_push),
            .i_push_dat(io_write_data[g*WORD_WIDTH +: WORD_WIDTH]),
            .i_pop     (w_out_pop),
            .o_head_dat(ext_out_data[g*WORD_WIDTH +: WORD_WIDTH]),
            .o_count   (w_out_cnt)
        );

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) r_perr <= 1'b0;
            else if ((io_rden[g] & w_in_empty) | (io_wren[g] & w_out_full)) r_perr <= 1'b1;
        end

        assign ext_in_ready[g]   = ~w_in_full;
        assign io_read_EF[g]     = ~w_in_empty;
        assign io_write_EF[g]    = w_out_full;
        assign ext_out_valid[g]  = ~w_out_empty;
        assign protocol_error[g] = r_perr;

`ifdef IO_PORT_FIFO_BANK_OCCUPANCY_EN
        assign in_count[g*(DEPTH_WIDTH+1) +: DEPTH_WIDTH+1]  = w_in_cnt;
        assign out_count[g*(DEPTH_WIDTH+1) +: DEPTH_WIDTH+1] = w_out_cnt;
`endif
    end
endmodule

// File: tb/tb_io_port_fifo_bank.sv
// Randomized and directed checks of io_port_fifo_bank against a queue-based reference model.
module tb_io_port_fifo_bank;
    localparam int W  = 36;
    localparam int P  = 3;
    localparam int D  = 4;
    localparam int DW = 2;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [P-1:0]     io_rden = '0;
    logic [P*W-1:0]   io_read_data;
    logic [P-1:0]     io_read_EF;
    logic [P-1:0]     io_wren = '0;
    logic [P*W-1:0]   io_write_data = '0;
    logic [P-1:0]     io_write_EF;
    logic [P-1:0]     ext_in_valid = '0;
    logic [P-1:0]     ext_in_ready;
    logic [P*W-1:0]   ext_in_data = '0;
    logic [P-1:0]     ext_out_valid;
    logic [P-1:0]     ext_out_ready = '0;
    logic [P*W-1:0]   ext_out_data;
    logic [P-1:0]     protocol_error;
`ifdef IO_PORT_FIFO_BANK_OCCUPANCY_EN
    logic [P*(DW+1)-1:0] in_count;
    logic [P*(DW+1)-1:0] out_count;
`endif

    always #5 clock = ~clock;

    io_port_fifo_bank #(.WORD_WIDTH(W), .PORT_COUNT(P), .DEPTH(D), .DEPTH_WIDTH(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .io_rden(io_rden), .io_read_data(io_read_data), .io_read_EF(io_read_EF),
        .io_wren(io_wren), .io_write_data(io_write_data), .io_write_EF(io_write_EF),
        .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready), .ext_in_data(ext_in_data),
        .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready), .ext_out_data(ext_out_data),
        .protocol_error(protocol_error)
`ifdef IO_PORT_FIFO_BANK_OCCUPANCY_EN
        , .in_count(in_count), .out_count(out_count)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] in_q  [P][$];
    logic [W-1:0] out_q [P][$];
    logic [P-1:0] m_perr = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < P; p++) begin
            in_q[p].delete();
            out_q[p].delete();
        end
        m_perr = '0;
    endtask

    task automatic check_all();
        logic [P*W-1:0] e_rd, e_od;
        logic [P-1:0]   e_ref, e_rdy, e_wef, e_ovl;
`ifdef IO_PORT_FIFO_BANK_OCCUPANCY_EN
        logic [P*(DW+1)-1:0] e_ic, e_oc;
`endif
        e_rd = '0;
        e_od = '0;
        for (int p = 0; p < P; p++) begin
            e_ref[p] = (in_q[p].size() != 0);
            e_rdy[p] = (in_q[p].size() != D);
            e_wef[p] = (out_q[p].size() == D);
            e_ovl[p] = (out_q[p].size() != 0);
            if (e_ref[p]) e_rd[p*W +: W] = in_q[p][0];
            if (e_ovl[p]) e_od[p*W +: W] = out_q[p][0];
`ifdef IO_PORT_FIFO_BANK_OCCUPANCY_EN
            e_ic[p*(DW+1) +: DW+1] = (DW+1)'(in_q[p].size());
            e_oc[p*(DW+1) +: DW+1] = (DW+1)'(out_q[p].size());
`endif
        end
        chk("io_read_EF",     128'(io_read_EF),     128'(e_ref));
        chk("io_read_data",   128'(io_read_data),   128'(e_rd));
        chk("ext_in_ready",   128'(ext_in_ready),   128'(e_rdy));
        chk("io_write_EF",    128'(io_write_EF),    128'(e_wef));
        chk("ext_out_valid",  128'(ext_out_valid),  128'(e_ovl));
        chk("ext_out_data",   128'(ext_out_data),   128'(e_od));
        chk("protocol_error", 128'(protocol_error), 128'(m_perr));
`ifdef IO_PORT_FIFO_BANK_OCCUPANCY_EN
        chk("in_count",  128'(in_count),  128'(e_ic));
        chk("out_count", 128'(out_count), 128'(e_oc));
`endif
    endtask

    // One clock: decide legality from pre-edge model state, advance, then compare.
    task automatic cycle();
        bit           ip[P], ipo[P], op[P], opo[P];
        logic [W-1:0] idat[P], odat[P];
        logic [P-1:0] err;
        err = '0;
        for (int p = 0; p < P; p++) begin
            ip[p]   = ext_in_valid[p] && (in_q[p].size() < D);
            ipo[p]  = io_rden[p] && (in_q[p].size() > 0);
            op[p]   = io_wren[p] && (out_q[p].size() < D);
            opo[p]  = ext_out_ready[p] && (out_q[p].size() > 0);
            err[p]  = (io_rden[p] && in_q[p].size() == 0) || (io_wren[p] && out_q[p].size() == D);
            idat[p] = ext_in_data[p*W +: W];
            odat[p] = io_write_data[p*W +: W];
        end
        @(posedge clock);
        #1;
        for (int p = 0; p < P; p++) begin
            if (ipo[p]) void'(in_q[p].pop_front());
            if (ip[p])  in_q[p].push_back(idat[p]);
            if (opo[p]) void'(out_q[p].pop_front());
            if (op[p])  out_q[p].push_back(odat[p]);
        end
        m_perr = m_perr | err;
        check_all();
    endtask

    task automatic idle_inputs();
        io_rden = '0;
        io_wren = '0;
        ext_in_valid = '0;
        ext_out_ready = '0;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        chk("reset_in_ready", 128'(ext_in_ready), 128'(3'b111));
        reset_n = 1'b1;

        // Inbound on port 0: 1,2,3 then three pops.
        ext_in_valid = 3'b001;
        for (int v = 1; v <= 3; v++) begin
            ext_in_data[0 +: W] = W'(v);
            cycle();
            if (v == 1) chk("t1_ef_rise", 128'(io_read_EF[0]), 128'(1));
        end
        ext_in_valid = '0;
        io_rden = 3'b001;
        for (int v = 1; v <= 3; v++) begin
            chk("t1_head", 128'(io_read_data[0 +: W]), 128'(v));
            cycle();
        end
        io_rden = '0;
        chk("t1_ef_drop", 128'(io_read_EF[0]), 128'(0));
        chk("t1_other_ef", 128'(io_read_EF[2:1]), 128'(0));

        // Outbound on port 2: fill, overflow, drain.
        io_wren = 3'b100;
        for (int v = 5; v <= 9; v++) begin
            io_write_data[2*W +: W] = W'(v);
            cycle();
            if (v == 8) chk("t2_full", 128'(io_write_EF[2]), 128'(1));
        end
        io_wren = '0;
        chk("t2_perr", 128'(protocol_error[2]), 128'(1));
        ext_out_ready = 3'b100;
        for (int v = 5; v <= 8; v++) begin
            chk("t2_drain", 128'(ext_out_data[2*W +: W]), 128'(v));
            cycle();
        end
        chk("t2_empty", 128'(ext_out_valid[2]), 128'(0));
        ext_out_ready = '0;

        // Port 1 steady state at two words with push+pop every cycle.
        ext_in_valid = 3'b010;
        for (int v = 16; v <= 17; v++) begin
            ext_in_data[W +: W] = W'(v);
            cycle();
        end
        io_rden = 3'b010;
        for (int k = 0; k < 10; k++) begin
            ext_in_data[W +: W] = W'(9 + k);
            chk("t3_head", 128'(io_read_data[W +: W]), 128'((k < 2) ? 16 + k : 7 + k));
            cycle();
            chk("t3_ready", 128'(ext_in_ready[1]), 128'(1));
        end
        ext_in_valid = '0;
        cycle();
        cycle();

        // Underflow read on port 1.
        cycle();
        io_rden = '0;
        chk("t4_data_zero", 128'(io_read_data[W +: W]), 128'(0));
        cycle();
        chk("t4_perr_sticky", 128'(protocol_error[1]), 128'(1));

        // Fill port 0, then reset between edges.
        ext_in_valid = 3'b001;
        for (int k = 0; k < 4; k++) begin
            ext_in_data[0 +: W] = {4'($urandom), 32'($urandom)};
            cycle();
        end
        idle_inputs();
        chk("t5_full", 128'(ext_in_ready[0]), 128'(0));
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_ready", 128'(ext_in_ready), 128'(3'b111));
        chk("t5_rst_ef", 128'(io_read_EF), 128'(0));
        chk("t5_rst_data", 128'(io_read_data), 128'(0));
        chk("t5_rst_perr", 128'(protocol_error), 128'(0));
        check_all();
        #1 reset_n = 1'b1;

`ifdef IO_PORT_FIFO_BANK_OCCUPANCY_EN
        ext_in_valid = 3'b100;
        for (int k = 0; k < 3; k++) begin
            ext_in_data[2*W +: W] = W'(k + 40);
            cycle();
        end
        ext_in_valid = '0;
        chk("t6_count3", 128'(in_count[2*(DW+1) +: DW+1]), 128'(3));
        io_rden = 3'b100;
        cycle();
        io_rden = '0;
        chk("t6_count2", 128'(in_count[2*(DW+1) +: DW+1]), 128'(2));
`endif

        // Random traffic in phases biased toward filling, draining or balance.
        for (int i = 0; i < 450; i++) begin
            int prod, cons;
            case ((i / 30) % 3)
                0:       begin prod = 85; cons = 20; end
                1:       begin prod = 20; cons = 85; end
                default: begin prod = 60; cons = 60; end
            endcase
            for (int p = 0; p < P; p++) begin
                ext_in_valid[p]  = ($urandom_range(0, 99) < prod);
                io_wren[p]       = ($urandom_range(0, 99) < prod);
                io_rden[p]       = ($urandom_range(0, 99) < cons);
                ext_out_ready[p] = ($urandom_range(0, 99) < cons);
                ext_in_data[p*W +: W]   = {4'($urandom), 32'($urandom)};
                io_write_data[p*W +: W] = {4'($urandom), 32'($urandom)};
            end
            cycle();
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
